imem_line_fill: RTL and testbench

- Instruction-memory line server directly downstream of the fetch-side instruction cache.
- Accepts a line-fill request (line index), waits a programmable access latency, then reads four 32-bit words from its backing store, one per cycle.
- Returns the assembled 128-bit line with a one-cycle valid pulse.
- Also provides a word-wide preload port so a loader or testbench can fill program memory after reset.

---
 rtl/imem_line_fill_pkg.sv | 26 ++
 rtl/imem_line_fill_if.sv | 25 ++
 rtl/imem_line_fill_word_ram.sv | 23 ++
 rtl/imem_line_fill.sv | 135 +++++++++++++
 tb/tb_imem_line_fill.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_line_fill_pkg.sv
// Shared types and constants for the instruction-memory line server.
// The FSM encoding matches the values reported by debug tooling.
package imem_line_fill_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_READ = 2'd2,
        ST_RESP = 2'd3
    } fill_state_e;

    localparam int LINE_WORDS = 4;
    localparam int WORD_W     = 32;
    localparam int LINE_W     = LINE_WORDS * WORD_W;

    localparam logic [WORD_W-1:0] NOP_WORD = 32'h2000_0000;

    // The wait counter counts down to zero inclusive, so it is preset one below the latency.
    function automatic logic [3:0] wait_preset(input int unsigned lat);
        if (lat == 0) begin
            return 4'd0;
        end
        return 4'(lat - 1);
    endfunction

endpackage

// File: rtl/imem_line_fill_if.sv
// Line-fill request/response bundle between the fetch cache (master) and the line server (slave).
interface imem_line_fill_if #(
    parameter int LINE_BITS = 10
);
    import imem_line_fill_pkg::*;

    logic                 Ic_mem_req;
    logic [LINE_BITS-1:0] Ic_mem_addr;
    logic [LINE_W-1:0]    F_mem_inst;
    logic                 F_mem_valid;

    modport master (
        output Ic_mem_req,
        output Ic_mem_addr,
        input  F_mem_inst,
        input  F_mem_valid
    );

    modport slave (
        input  Ic_mem_req,
        input  Ic_mem_addr,
        output F_mem_inst,
        output F_mem_valid
    );
endinterface

// File: rtl/imem_line_fill_word_ram.sv
// Program word store: one synchronous write port, one asynchronous read port.
// A write and a read of the same word in one cycle return the old contents.
module imem_word_ram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/imem_line_fill.sv
// Serves 128-bit instruction lines: accept a line index, wait LATENCY cycles,
// read four words one per cycle, then pulse F_mem_valid for one cycle.
module imem_line_fill
    import imem_line_fill_pkg::*;
#(
    parameter int PC_BITS   = 12,
    parameter int LINE_BITS = 10,
    parameter int LATENCY   = 4
) (
    input  logic                clk,
    input  logic                rst,
    imem_line_fill_if.slave     fill,
    input  logic                ld_we,
    input  logic [PC_BITS-1:0]  ld_addr,
    input  logic [WORD_W-1:0]   ld_data,
    output logic                fill_busy
);
    localparam int         IDX_W     = PC_BITS - 2;
    localparam logic [3:0] WAIT_INIT = wait_preset(LATENCY);

    fill_state_e        state_q, state_d;
    logic [IDX_W-1:0]   line_q, line_d;
    logic [3:0]         wait_q, wait_d;
    logic [1:0]         beat_q, beat_d;
    logic [IDX_W-1:0]   req_idx;
    logic [PC_BITS-1:0] rd_addr;
    logic [WORD_W-1:0]  rd_data;
    logic [LINE_W-1:0]  inst_bus;

    // Line index bits beyond the store size are dropped so addresses wrap.
    generate
        if (LINE_BITS >= IDX_W) begin : g_trunc
            assign req_idx = fill.Ic_mem_addr[IDX_W-1:0];
            if (LINE_BITS > IDX_W) begin : g_drop
                logic unused_hi_bits;
                assign unused_hi_bits = ^fill.Ic_mem_addr[LINE_BITS-1:IDX_W];
            end
        end else begin : g_ext
            assign req_idx = {{(IDX_W - LINE_BITS){1'b0}}, fill.Ic_mem_addr};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        wait_d  = wait_q;
        beat_d  = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (fill.Ic_mem_req) begin
                    line_d = req_idx;
                    beat_d = 2'd0;
                    wait_d = WAIT_INIT;
                    state_d = (LATENCY == 0) ? ST_READ : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_q == 4'd0) begin
                    state_d = ST_READ;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_READ: begin
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            line_q  <= '0;
            wait_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            wait_q  <= wait_d;
            beat_q  <= beat_d;
        end
    end

    assign rd_addr = {line_q, beat_q};

    imem_word_ram #(
        .ADDR_W (PC_BITS),
        .DATA_W (WORD_W)
    ) u_ram (
        .clk   (clk),
        .we    (ld_we),
        .waddr (ld_addr),
        .wdata (ld_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Each slot captures the store word on its own beat and holds it until the next fill.
    genvar gi;
    generate
        for (gi = 0; gi < LINE_WORDS; gi++) begin : g_slot
            logic [WORD_W-1:0] slot_q, slot_d;

            always_comb begin
                slot_d = slot_q;
                if (state_q == ST_READ && beat_q == 2'(gi)) begin
                    slot_d = rd_data;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    slot_q <= '0;
                end else begin
                    slot_q <= slot_d;
                end
            end

            assign inst_bus[gi*WORD_W +: WORD_W] = slot_q;
        end
    endgenerate

    assign fill.F_mem_inst  = inst_bus;
    assign fill.F_mem_valid = (state_q == ST_RESP);
    assign fill_busy        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_imem_line_fill.sv
// Drives three builds (LATENCY=4, LATENCY=0, PC_BITS=10) with directed fills and checks
// every cycle against a timing/contents model of the line server.
module tb_imem_line_fill;
    import imem_line_fill_pkg::*;

    localparam int N = 3;

    function automatic int lat_of(input int k);
        return (k == 1) ? 0 : 4;
    endfunction

    function automatic int pcb_of(input int k);
        return (k == 2) ? 10 : 12;
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         req   [N];
    logic [9:0]   addr  [N];
    logic         we    [N];
    logic [11:0]  waddr [N];
    logic [31:0]  wdata [N];
    logic [127:0] inst  [N];
    logic         valid [N];
    logic         busy  [N];
    logic         busy_a, busy_b, busy_c;

    imem_line_fill_if #(.LINE_BITS(10)) if_a ();
    imem_line_fill_if #(.LINE_BITS(10)) if_b ();
    imem_line_fill_if #(.LINE_BITS(10)) if_c ();

    assign if_a.Ic_mem_req  = req[0];
    assign if_a.Ic_mem_addr = addr[0];
    assign if_b.Ic_mem_req  = req[1];
    assign if_b.Ic_mem_addr = addr[1];
    assign if_c.Ic_mem_req  = req[2];
    assign if_c.Ic_mem_addr = addr[2];

    always_comb begin
        inst[0]  = if_a.F_mem_inst;
        inst[1]  = if_b.F_mem_inst;
        inst[2]  = if_c.F_mem_inst;
        valid[0] = if_a.F_mem_valid;
        valid[1] = if_b.F_mem_valid;
        valid[2] = if_c.F_mem_valid;
        busy[0]  = busy_a;
        busy[1]  = busy_b;
        busy[2]  = busy_c;
    end

    imem_line_fill #(.PC_BITS(12), .LINE_BITS(10), .LATENCY(4)) dut_a (
        .clk(clk), .rst(rst), .fill(if_a),
        .ld_we(we[0]), .ld_addr(waddr[0]), .ld_data(wdata[0]), .fill_busy(busy_a));

    imem_line_fill #(.PC_BITS(12), .LINE_BITS(10), .LATENCY(0)) dut_b (
        .clk(clk), .rst(rst), .fill(if_b),
        .ld_we(we[1]), .ld_addr(waddr[1]), .ld_data(wdata[1]), .fill_busy(busy_b));

    imem_line_fill #(.PC_BITS(10), .LINE_BITS(10), .LATENCY(4)) dut_c (
        .clk(clk), .rst(rst), .fill(if_c),
        .ld_we(we[2]), .ld_addr(waddr[2][9:0]), .ld_data(wdata[2]), .fill_busy(busy_c));

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int k, input logic [127:0] act,
                         input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut=%0d got=%h want=%h", name, k, act, exp);
        end
    endtask

    // Model: a fill accepted at edge 0 reads word b at edge LAT+1+b (before any
    // same-edge preload), is valid in the cycle after edge LAT+4, idle after LAT+5.
    logic [31:0]  mm     [N][4096];
    bit           m_busy [N];
    bit           m_valid[N];
    int           m_t    [N];
    int           m_line [N];
    logic [127:0] m_inst [N];

    initial begin
        forever begin
            @(posedge clk);
            for (int k = 0; k < N; k++) begin
                int size, lat, b;
                size = 1 << pcb_of(k);
                lat  = lat_of(k);
                if (rst) begin
                    m_busy[k]  = 1'b0;
                    m_valid[k] = 1'b0;
                    m_inst[k]  = '0;
                end else if (!m_busy[k]) begin
                    m_valid[k] = 1'b0;
                    if (req[k]) begin
                        m_busy[k] = 1'b1;
                        m_t[k]    = 0;
                        m_line[k] = int'(addr[k]) % (size / 4);
                    end
                end else begin
                    m_t[k]++;
                    if (m_t[k] >= lat + 1 && m_t[k] <= lat + 4) begin
                        b = m_t[k] - lat - 1;
                        m_inst[k][b*32 +: 32] = mm[k][m_line[k]*4 + b];
                    end
                    m_valid[k] = (m_t[k] == lat + 4);
                    if (m_t[k] == lat + 5) begin
                        m_busy[k] = 1'b0;
                    end
                end
                if (we[k]) begin
                    mm[k][int'(waddr[k]) % size] = wdata[k];
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int k = 0; k < N; k++) begin
                    check("valid", k, {127'd0, valid[k]}, {127'd0, m_valid[k]});
                    check("busy",  k, {127'd0, busy[k]},  {127'd0, m_busy[k]});
                    check("inst",  k, inst[k], m_inst[k]);
                end
            end
        end
    end

    task automatic preload(input int k, input int a, input logic [31:0] d);
        @(negedge clk);
        we[k]    = 1'b1;
        waddr[k] = 12'(a);
        wdata[k] = d;
        @(negedge clk);
        we[k] = 1'b0;
    endtask

    // cyc counts negedges after the request was raised; valid seen at cyc means
    // it arrived cyc-1 cycles after the acceptance edge.
    task automatic do_fill(input int k, input int line, input int chg_at, input int chg_line,
                           input int we_at, input int we_a, input logic [31:0] we_d,
                           input bit keep_req, output int cyc, output logic [127:0] data);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        data = '0;
        @(negedge clk);
        req[k]  = 1'b1;
        addr[k] = 10'(line);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            cyc++;
            if (valid[k]) begin
                seen = 1'b1;
                data = inst[k];
            end
            if (cyc == we_at) begin
                we[k]    = 1'b1;
                waddr[k] = 12'(we_a);
                wdata[k] = we_d;
            end else begin
                we[k] = 1'b0;
            end
            if (cyc == chg_at) begin
                addr[k] = 10'(chg_line);
            end
        end
        we[k] = 1'b0;
        if (!keep_req) begin
            req[k] = 1'b0;
        end
        check("valid_seen", k, {127'd0, seen}, 128'd1);
        $display("fill dut=%0d line=%03h accept_to_valid=%0d data=%h", k, line, cyc - 1, data);
    endtask

    int           cyc, cyc2, vcnt;
    logic [127:0] d, d2;

    initial begin
        for (int k = 0; k < N; k++) begin
            req[k] = 1'b0; addr[k] = '0; we[k] = 1'b0; waddr[k] = '0; wdata[k] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check("rst_inst",  k, inst[k], 128'd0);
            check("rst_valid", k, {127'd0, valid[k]}, 128'd0);
            check("rst_busy",  k, {127'd0, busy[k]},  128'd0);
        end

        for (int i = 0; i < 8; i++) preload(0, i, 32'h1000_0000 + 32'(i));
        for (int i = 0; i < 4; i++) preload(0, 12'hFFC + i, 32'hA000_0000 + 32'(i));
        for (int i = 0; i < 4; i++) preload(1, i, 32'h1000_0000 + 32'(i));
        for (int i = 0; i < 4; i++) preload(2, i, 32'h3000_0000 + 32'(i));
        preload(2, 12'h3FC, NOP_WORD);

        do_fill(0, 1, -1, 0, -1, 0, 0, 1'b0, cyc, d);
        check("lat4_cycles", 0, 128'(cyc - 1), 128'd8);
        check("lat4_line1", 0, d, 128'h10000007_10000006_10000005_10000004);

        do_fill(1, 0, -1, 0, -1, 0, 0, 1'b0, cyc, d);
        check("lat0_cycles", 1, 128'(cyc - 1), 128'd4);
        check("lat0_line0", 1, d, 128'h10000003_10000002_10000001_10000000);
        @(negedge clk);
        check("lat0_pulse", 1, {127'd0, valid[1]}, 128'd0);

        do_fill(0, 1, -1, 0, -1, 0, 0, 1'b1, cyc, d);
        do_fill(0, 0, 3, 5, -1, 0, 0, 1'b0, cyc2, d2);
        check("b2b_first", 0, d, 128'h10000007_10000006_10000005_10000004);
        check("b2b_second", 0, d2, 128'h10000003_10000002_10000001_10000000);
        check("b2b_cycles", 0, 128'(cyc2 - 1), 128'd8);

        do_fill(0, 1, -1, 0, 7, 6, 32'hDEAD_BEEF, 1'b0, cyc, d);
        check("rbw_slot2", 0, {96'd0, d[95:64]}, 128'h1000_0006);
        do_fill(0, 1, -1, 0, -1, 0, 0, 1'b0, cyc, d);
        check("refetch_slot2", 0, {96'd0, d[95:64]}, 128'hDEAD_BEEF);

        @(negedge clk);
        req[0]  = 1'b1;
        addr[0] = 10'd0;
        repeat (3) @(negedge clk);
        req[0] = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (valid[0]) vcnt++;
        end
        check("rst_abort_valid", 0, 128'(vcnt), 128'd0);
        check("rst_abort_inst", 0, inst[0], 128'd0);
        check("rst_abort_busy", 0, {127'd0, busy[0]}, 128'd0);
        do_fill(0, 0, -1, 0, -1, 0, 0, 1'b0, cyc, d);
        check("post_rst_line0", 0, d, 128'h10000003_10000002_10000001_10000000);

        do_fill(0, 10'h3FF, -1, 0, -1, 0, 0, 1'b0, cyc, d);
        check("top_line", 0, d, 128'hA0000003_A0000002_A0000001_A0000000);
        do_fill(2, 10'h400 & 10'h3FF, -1, 0, -1, 0, 0, 1'b0, cyc, d);
        check("c_line0", 2, d, 128'h30000003_30000002_30000001_30000000);
        do_fill(2, 10'h3FF, -1, 0, -1, 0, 0, 1'b0, cyc, d);
        check("c_wrap_3ff", 2, {96'd0, d[31:0]}, {96'd0, NOP_WORD});

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
